pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_if.sv | 49 ++++
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle of the pipeline-control signals exchanged between the
// Y86 datapath (master) and the pipeline control unit (slave).
//   master : drives stage icodes, register ids, condition, statuses and the
//            next ALU flags; receives CC flags, stall/bubble controls,
//            halted indication and performance counters.
//   slave  : the pipe_ctrl block, the mirror image of master.
interface pipe_ctrl_if;
  logic [3:0]  D_icode_i;
  logic [3:0]  E_icode_i;
  logic [3:0]  M_icode_i;
  logic [3:0]  E_dstM_i;
  logic [3:0]  d_srcA_i;
  logic [3:0]  d_srcB_i;
  logic        e_Cnd_i;
  logic [2:0]  m_stat_i;
  logic [2:0]  W_stat_i;
  logic        zf_i;
  logic        sf_i;
  logic        of_i;
  logic        zf_o;
  logic        sf_o;
  logic        of_o;
  logic        set_cc_o;
  logic        F_stall_o;
  logic        D_stall_o;
  logic        D_bubble_o;
  logic        E_bubble_o;
  logic        M_bubble_o;
  logic        W_stall_o;
  logic        halted_o;
  logic [15:0] stall_cycles_o;
  logic [15:0] bubble_cycles_o;

  modport master (
    output D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
    output e_Cnd_i, m_stat_i, W_stat_i, zf_i, sf_i, of_i,
    input  zf_o, sf_o, of_o, set_cc_o,
    input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
    input  halted_o, stall_cycles_o, bubble_cycles_o
  );

  modport slave (
    input  D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
    input  e_Cnd_i, m_stat_i, W_stat_i, zf_i, sf_i, of_i,
    output zf_o, sf_o, of_o, set_cc_o,
    output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
    output halted_o, stall_cycles_o, bubble_cycles_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage Y86 pipeline.
// Generates stall/bubble controls for the F/D/E/M/W registers (load/use,
// ret, branch mispredict, exception), holds the condition-code register and
// runs the RUN/HALT state machine that freezes the pipeline once a non-AOK
// status reaches write-back.
// Ports:
//   clk  : pipeline clock
//   rst  : synchronous reset, active-low
//   bus  : pipe_ctrl_if.slave (stage icodes/ids/statuses and next flags in;
//          CC flags, set_cc, stall/bubble controls, halted, counters out)
// Optional build macro: PIPE_CTRL_PERF_EN enables the 16-bit saturating
// stall/bubble cycle counters; without it both counter outputs are 0.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPL   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SADR    = 3'd2;
  localparam logic [2:0] SINS    = 3'd3;
  localparam logic [2:0] SHLT    = 3'd4;

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

  // Non-AOK status that must stop the pipeline.
  function automatic logic exc(input logic [2:0] s);
    case (s)
      SADR, SINS, SHLT: exc = 1'b1;
      default:          exc = 1'b0;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [2:0] cc_q, cc_d;   // {zf, sf, of}
  logic       lu, ret_hit, mis, m_exc, w_exc;
  logic       f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc;

  // Hazard terms decoded from the stage registers.
  always_comb begin
    lu      = ((bus.E_icode_i == IMRMOVL) || (bus.E_icode_i == IPOPL)) &&
              (bus.E_dstM_i != RNONE) &&
              ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
    ret_hit = (bus.D_icode_i == IRET) || (bus.E_icode_i == IRET) ||
              (bus.M_icode_i == IRET);
    mis     = (bus.E_icode_i == IJXX) && !bus.e_Cnd_i;
    m_exc   = exc(bus.m_stat_i);
    w_exc   = exc(bus.W_stat_i);
  end

  // Stall/bubble/set_cc generation; reset and HALT override the hazard logic.
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_stall  = 1'b0;
    set_cc   = 1'b0;
    if (!rst) begin
      d_bubble = 1'b1;
      e_bubble = 1'b1;
      m_bubble = 1'b1;
    end else if (state_q == S_HALT) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      w_stall  = 1'b1;
      m_bubble = 1'b1;
    end else begin
      f_stall  = lu || ret_hit;
      d_stall  = lu;
      // A load/use stall holds D, so ret must not also bubble it.
      d_bubble = mis || (!lu && ret_hit);
      e_bubble = mis || lu;
      m_bubble = m_exc || w_exc;
      w_stall  = w_exc;
      // Flags must not change once an exception is downstream of the OPL.
      set_cc   = (bus.E_icode_i == IOPL) && !m_exc && !w_exc;
    end
  end

  // Next-state and CC next value.
  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    if (set_cc) begin
      cc_d = {bus.zf_i, bus.sf_i, bus.of_i};
    end else begin
      cc_d = cc_q;
    end
    if ((state_q == S_RUN) && w_exc) begin
      state_d = S_HALT;
    end else begin
      state_d = state_q;
    end
  end

  // FSM state and CC register; HALT is left only through reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      cc_q    <= 3'b100;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
    end
  end

  assign bus.zf_o       = cc_q[2];
  assign bus.sf_o       = cc_q[1];
  assign bus.of_o       = cc_q[0];
  assign bus.set_cc_o   = set_cc;
  assign bus.F_stall_o  = f_stall;
  assign bus.D_stall_o  = d_stall;
  assign bus.D_bubble_o = d_bubble;
  assign bus.E_bubble_o = e_bubble;
  assign bus.M_bubble_o = m_bubble;
  assign bus.W_stall_o  = w_stall;
  assign bus.halted_o   = (state_q == S_HALT);

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters advance only in RUN, so they freeze in HALT.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if ((state_q == S_RUN) && (f_stall || d_stall) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if ((state_q == S_RUN) && e_bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q  <= 16'h0000;
      bubble_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.stall_cycles_o  = stall_cnt_q;
  assign bus.bubble_cycles_o = bubble_cnt_q;
`else
  assign bus.stall_cycles_o  = 16'h0000;
  assign bus.bubble_cycles_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl. Directed steps follow the
// block's intended behaviour, then randomized stimulus is compared against a
// behavioural model of the hazard rules, CC register, halt state and counters.
module tb_pipe_ctrl;

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPL   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SADR    = 3'd2;
  localparam logic [2:0] SINS    = 3'd3;
  localparam logic [2:0] SHLT    = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // model state
  logic       m_halt;
  logic [2:0] m_cc;
  int         m_stall_cnt;
  int         m_bub_cnt;

  pipe_ctrl_if pif ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.slave)
  );

  always #5 clk = ~clk;

  function automatic bit is_exc(input logic [2:0] s);
    return s inside {SADR, SINS, SHLT};
  endfunction

  // Expected {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}.
  function automatic logic [6:0] ref_ctrl();
    bit lu, rt, mp, me, we;
    if (!rst) return 7'b0011100;
    if (m_halt) return 7'b1100110;
    lu = (pif.E_icode_i inside {IMRMOVL, IPOPL}) && (pif.E_dstM_i != RNONE) &&
         (pif.E_dstM_i == pif.d_srcA_i || pif.E_dstM_i == pif.d_srcB_i);
    rt = (pif.D_icode_i == IRET) || (pif.E_icode_i == IRET) || (pif.M_icode_i == IRET);
    mp = (pif.E_icode_i == IJXX) && !pif.e_Cnd_i;
    me = is_exc(pif.m_stat_i);
    we = is_exc(pif.W_stat_i);
    return {lu | rt, lu, mp | (!lu & rt), mp | lu, me | we, we,
            (pif.E_icode_i == IOPL) & !me & !we};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] d, input logic [3:0] e, input logic [3:0] m,
                        input logic [3:0] dm, input logic [3:0] sa, input logic [3:0] sb,
                        input logic cnd, input logic [2:0] ms, input logic [2:0] ws);
    pif.D_icode_i = d;  pif.E_icode_i = e;  pif.M_icode_i = m;
    pif.E_dstM_i  = dm; pif.d_srcA_i  = sa; pif.d_srcB_i  = sb;
    pif.e_Cnd_i   = cnd; pif.m_stat_i = ms; pif.W_stat_i  = ws;
  endtask

  task automatic set_flags(input logic z, input logic s, input logic o);
    pif.zf_i = z; pif.sf_i = s; pif.of_i = o;
  endtask

  task automatic nop_in();
    set_in(INOP, INOP, INOP, RNONE, RNONE, RNONE, 1'b1, SAOK, SAOK);
  endtask

  // Check every output against the model, clock once, advance the model.
  task automatic cycle();
    logic [6:0] e;
    int es, eb;
    #1;
    e = ref_ctrl();
`ifdef PIPE_CTRL_PERF_EN
    es = m_stall_cnt; eb = m_bub_cnt;
`else
    es = 0; eb = 0;
`endif
    chk("ctrl", 32'({pif.F_stall_o, pif.D_stall_o, pif.D_bubble_o, pif.E_bubble_o,
                     pif.M_bubble_o, pif.W_stall_o, pif.set_cc_o}), 32'(e));
    chk("cc", 32'({pif.zf_o, pif.sf_o, pif.of_o}), 32'(m_cc));
    chk("halted", 32'(pif.halted_o), 32'(m_halt));
    chk("stall_cnt", 32'(pif.stall_cycles_o), 32'(es));
    chk("bubble_cnt", 32'(pif.bubble_cycles_o), 32'(eb));
    @(posedge clk);
    if (!rst) begin
      m_halt = 1'b0; m_cc = 3'b100; m_stall_cnt = 0; m_bub_cnt = 0;
    end else begin
      if (e[0]) m_cc = {pif.zf_i, pif.sf_i, pif.of_i};
      if (!m_halt) begin
        if ((e[6] || e[5]) && m_stall_cnt < 65535) m_stall_cnt++;
        if (e[3] && m_bub_cnt < 65535) m_bub_cnt++;
        if (is_exc(pif.W_stat_i)) m_halt = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    nop_in();
    set_flags(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_halt = 1'b0; m_cc = 3'b100; m_stall_cnt = 0; m_bub_cnt = 0;

    // reset forcing and reset CC value
    set_in(INOP, IMRMOVL, INOP, 4'd3, 4'd3, RNONE, 1'b1, SAOK, SHLT);
    #1;
    chk("rst_bubbles", 32'({pif.D_bubble_o, pif.E_bubble_o, pif.M_bubble_o}), 32'd7);
    chk("rst_stalls", 32'({pif.F_stall_o, pif.D_stall_o, pif.W_stall_o}), 32'd0);
    chk("rst_cc", 32'({pif.zf_o, pif.sf_o, pif.of_o}), 32'b100);
    cycle();
    nop_in();
    rst = 1'b1;

    // load/use
    set_in(INOP, IMRMOVL, INOP, 4'd3, 4'd3, 4'd0, 1'b1, SAOK, SAOK);
    #1;
    chk("lu_stall", 32'({pif.F_stall_o, pif.D_stall_o, pif.E_bubble_o, pif.D_bubble_o}), 32'b1110);
    cycle();
    set_in(INOP, IMRMOVL, INOP, RNONE, RNONE, 4'd0, 1'b1, SAOK, SAOK);
    #1;
    chk("lu_rnone", 32'({pif.F_stall_o, pif.D_stall_o, pif.E_bubble_o, pif.D_bubble_o}), 32'b0000);
    cycle();

    // ret walked through D, E, M
    set_in(IRET, INOP, INOP, RNONE, RNONE, RNONE, 1'b1, SAOK, SAOK);
    #1; chk("ret_d", 32'({pif.F_stall_o, pif.D_bubble_o}), 32'b11); cycle();
    set_in(INOP, IRET, INOP, RNONE, RNONE, RNONE, 1'b1, SAOK, SAOK);
    #1; chk("ret_e", 32'({pif.F_stall_o, pif.D_bubble_o}), 32'b11); cycle();
    set_in(INOP, INOP, IRET, RNONE, RNONE, RNONE, 1'b1, SAOK, SAOK);
    #1; chk("ret_m", 32'({pif.F_stall_o, pif.D_bubble_o}), 32'b11); cycle();
    nop_in();
    #1; chk("ret_done", 32'({pif.F_stall_o, pif.D_bubble_o}), 32'b00); cycle();

    // mispredict together with ret in D
    set_in(IRET, IJXX, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK);
    #1; chk("mis_ret", 32'({pif.D_bubble_o, pif.E_bubble_o, pif.F_stall_o}), 32'b111); cycle();
    set_in(IRET, IJXX, INOP, RNONE, RNONE, RNONE, 1'b1, SAOK, SAOK);
    #1; chk("taken_ret", 32'({pif.D_bubble_o, pif.E_bubble_o, pif.F_stall_o}), 32'b101); cycle();

    // CC update and suppression by memory exception
    set_in(INOP, IOPL, INOP, RNONE, RNONE, RNONE, 1'b1, SAOK, SAOK);
    set_flags(1'b0, 1'b1, 1'b1);
    #1; chk("setcc", 32'(pif.set_cc_o), 32'd1); cycle();
    nop_in();
    #1; chk("cc_new", 32'({pif.zf_o, pif.sf_o, pif.of_o}), 32'b011); cycle();
    do_reset();
    set_in(INOP, IOPL, INOP, RNONE, RNONE, RNONE, 1'b1, SADR, SAOK);
    #1; chk("setcc_madr", 32'(pif.set_cc_o), 32'd0); cycle();
    nop_in();
    #1; chk("cc_kept", 32'({pif.zf_o, pif.sf_o, pif.of_o}), 32'b100); cycle();

    // halt entry with an OPL in E, hold, exit by reset
    set_in(INOP, IOPL, INOP, RNONE, RNONE, RNONE, 1'b1, SAOK, SHLT);
    #1; chk("halt_entry", 32'({pif.W_stall_o, pif.M_bubble_o, pif.set_cc_o}), 32'b110); cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(IRET, IMRMOVL, INOP, 4'd2, 4'd2, 4'd2, 1'b0, SAOK, SAOK);
      #1;
      chk("halted", 32'({pif.halted_o, pif.F_stall_o, pif.D_stall_o, pif.W_stall_o}), 32'b1111);
      chk("halt_cc", 32'({pif.zf_o, pif.sf_o, pif.of_o}), 32'b100);
      cycle();
    end
    do_reset();
    nop_in();
    #1; chk("halt_exit", 32'(pif.halted_o), 32'd0); cycle();

    // reset during a load/use stall drops the stall
    set_in(INOP, IPOPL, INOP, 4'd4, 4'd1, 4'd4, 1'b1, SAOK, SAOK);
    rst = 1'b0;
    #1; chk("rst_drops_stall", 32'({pif.F_stall_o, pif.D_stall_o}), 32'b00);
    cycle();
    rst = 1'b1;

    // randomized stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] sa;
      sa = 4'($urandom_range(0, 7));
      set_in(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
             ($urandom_range(0, 3) == 0) ? RNONE : (($urandom_range(0, 1) == 0) ? sa : 4'($urandom_range(0, 7))),
             sa, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : SAOK,
             ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : SAOK);
      set_flags(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rst = (m_halt ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 49) != 0));
      cycle();
    end
    rst = 1'b1;

`ifdef PIPE_CTRL_PERF_EN
    do_reset();
    set_in(INOP, IMRMOVL, INOP, 4'd3, 4'd3, 4'd0, 1'b1, SAOK, SAOK);
    for (int i = 0; i < 5; i++) cycle();
    set_in(INOP, IJXX, INOP, RNONE, RNONE, RNONE, 1'b0, SAOK, SAOK);
    for (int i = 0; i < 3; i++) cycle();
    nop_in();
    #1;
    chk("perf_stall", 32'(pif.stall_cycles_o), 32'd5);
    chk("perf_bubble", 32'(pif.bubble_cycles_o), 32'd8);
    set_in(INOP, IMRMOVL, INOP, 4'd3, 4'd3, 4'd0, 1'b1, SAOK, SAOK);
    for (int i = 0; i < 65540; i++) cycle();
    #1;
    chk("perf_sat_stall", 32'(pif.stall_cycles_o), 32'h0000FFFF);
    chk("perf_sat_bubble", 32'(pif.bubble_cycles_o), 32'h0000FFFF);
`else
    set_in(INOP, IMRMOVL, INOP, 4'd3, 4'd3, 4'd0, 1'b0, SAOK, SAOK);
    for (int i = 0; i < 3; i++) cycle();
    #1;
    chk("perf_off", 32'({pif.stall_cycles_o, pif.bubble_cycles_o}), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
